// File: rtl/piece_move_scheduler_if.sv
// Request/response bundle between the game controller and piece_move_scheduler.
interface piece_move_scheduler_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  // Requests are single-cycle pulses with no ready: a pulse is consumed only when the
  // scheduler is idle and wins arbitration, otherwise it is discarded (gravity is remembered).
  logic              req_left;
  logic              req_right;
  logic              req_down;
  logic              req_rot;
  logic              req_type;
  logic              req_drop;
  logic              grav_tick;
  logic [2:0]        spawn_type;
  logic              is_collided;
  logic [XW+YW-1:0]  try_pos;
  logic [1:0]        try_dir;
  logic [2:0]        try_type;
  logic [XW+YW-1:0]  cur_pos;
  logic [1:0]        cur_dir;
  logic [2:0]        cur_type;
  logic              place;
  logic              busy;
  logic              game_over;
  logic [2:0]        state_dbg;

  modport master (
    output req_left, req_right, req_down, req_rot, req_type, req_drop,
    output grav_tick, spawn_type, is_collided,
    input  try_pos, try_dir, try_type, cur_pos, cur_dir, cur_type,
    input  place, busy, game_over, state_dbg
  );

  modport slave (
    input  req_left, req_right, req_down, req_rot, req_type, req_drop,
    input  grav_tick, spawn_type, is_collided,
    output try_pos, try_dir, try_type, cur_pos, cur_dir, cur_type,
    output place, busy, game_over, state_dbg
  );
endinterface

// File: rtl/piece_move_scheduler.sv
// Falling-brick move scheduler: arbitrates key/gravity requests, checks candidates, places and spawns.
// Optional macro HARD_DROP_EN turns req_drop into a stepwise drop to the first collision.
module piece_move_scheduler #(
  parameter int XW      = 5,
  parameter int YW      = 5,
  parameter int SPAWN_X = 6,
  parameter int SPAWN_Y = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piece_move_scheduler_if.slave bus
);
  localparam int PW = XW + YW;
  localparam logic [PW-1:0] SPAWN_POS = {XW'(SPAWN_X), YW'(SPAWN_Y)};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    PLACE     = 3'd2,
    SPAWN     = 3'd3,
    SPAWN_CHK = 3'd4,
    OVER      = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] cur_pos, cur_pos_nxt, try_pos, try_pos_nxt;
  logic [1:0]    cur_dir, cur_dir_nxt, try_dir, try_dir_nxt;
  logic [2:0]    cur_type, cur_type_nxt, try_type, try_type_nxt;
  logic          pending, pending_nxt;
  logic          fall, fall_nxt;        // current CHECK came from down/gravity/drop
  logic          drop_run, drop_run_nxt;

  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y, try_y;
  logic [PW-1:0] pos_down;

  assign cur_x    = cur_pos[PW-1:YW];
  assign cur_y    = cur_pos[YW-1:0];
  assign try_y    = try_pos[YW-1:0];
  assign pos_down = {cur_x, cur_y - YW'(1)};

  always_comb begin
    state_nxt    = state;
    cur_pos_nxt  = cur_pos;
    cur_dir_nxt  = cur_dir;
    cur_type_nxt = cur_type;
    try_pos_nxt  = try_pos;
    try_dir_nxt  = try_dir;
    try_type_nxt = try_type;
    pending_nxt  = pending;
    fall_nxt     = fall;
    drop_run_nxt = drop_run;
    if (state != IDLE && state != OVER) pending_nxt = pending | bus.grav_tick;

    case (state)
      IDLE: begin
        pending_nxt  = 1'b0;
        fall_nxt     = 1'b0;
        drop_run_nxt = 1'b0;
        if (bus.req_drop) begin
          // A tick losing to drop is kept so it is not silently lost.
          pending_nxt = pending | bus.grav_tick;
`ifdef HARD_DROP_EN
          if (cur_y == '0) begin
            state_nxt = PLACE;
          end else begin
            try_pos_nxt  = pos_down;
            fall_nxt     = 1'b1;
            drop_run_nxt = 1'b1;
            state_nxt    = CHECK;
          end
`else
          state_nxt = PLACE;
`endif
        end else if (bus.grav_tick || pending || bus.req_down) begin
          if (cur_y == '0) begin
            state_nxt = PLACE;
          end else begin
            try_pos_nxt = pos_down;
            fall_nxt    = 1'b1;
            state_nxt   = CHECK;
          end
        end else if (bus.req_left) begin
          try_pos_nxt = {cur_x - XW'(1), cur_y};
          state_nxt   = CHECK;
        end else if (bus.req_right) begin
          try_pos_nxt = {cur_x + XW'(1), cur_y};
          state_nxt   = CHECK;
        end else if (bus.req_rot) begin
          try_dir_nxt = cur_dir + 2'd1;
          state_nxt   = CHECK;
        end else if (bus.req_type) begin
          try_type_nxt = (cur_type == 3'd7) ? 3'd1 : cur_type + 3'd1;
          state_nxt    = CHECK;
        end
      end

      CHECK: begin
        if (!bus.is_collided) begin
          cur_pos_nxt  = try_pos;
          cur_dir_nxt  = try_dir;
          cur_type_nxt = try_type;
          if (drop_run && try_y != '0) begin
            try_pos_nxt = {try_pos[PW-1:YW], try_y - YW'(1)};
          end else if (drop_run) begin
            state_nxt = PLACE;
          end else begin
            state_nxt = IDLE;
          end
        end else if (fall) begin
          state_nxt = PLACE;
        end else begin
          // Rejected sideways/rotate/type move: candidate falls back to the committed brick.
          try_pos_nxt  = cur_pos;
          try_dir_nxt  = cur_dir;
          try_type_nxt = cur_type;
          state_nxt    = IDLE;
        end
      end

      PLACE: begin
        fall_nxt     = 1'b0;
        drop_run_nxt = 1'b0;
        state_nxt    = SPAWN;
      end

      SPAWN: begin
        cur_pos_nxt  = SPAWN_POS;
        cur_dir_nxt  = 2'd0;
        cur_type_nxt = bus.spawn_type;
        try_pos_nxt  = SPAWN_POS;
        try_dir_nxt  = 2'd0;
        try_type_nxt = bus.spawn_type;
        state_nxt    = SPAWN_CHK;
      end

      SPAWN_CHK: state_nxt = bus.is_collided ? OVER : IDLE;

      OVER: state_nxt = OVER;

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_pos  <= SPAWN_POS;
      cur_dir  <= 2'd0;
      cur_type <= 3'd1;
      try_pos  <= SPAWN_POS;
      try_dir  <= 2'd0;
      try_type <= 3'd1;
      pending  <= 1'b0;
      fall     <= 1'b0;
      drop_run <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_pos  <= cur_pos_nxt;
      cur_dir  <= cur_dir_nxt;
      cur_type <= cur_type_nxt;
      try_pos  <= try_pos_nxt;
      try_dir  <= try_dir_nxt;
      try_type <= try_type_nxt;
      pending  <= pending_nxt;
      fall     <= fall_nxt;
      drop_run <= drop_run_nxt;
    end
  end

  assign bus.try_pos   = try_pos;
  assign bus.try_dir   = try_dir;
  assign bus.try_type  = try_type;
  assign bus.cur_pos   = cur_pos;
  assign bus.cur_dir   = cur_dir;
  assign bus.cur_type  = cur_type;
  assign bus.place     = (state == PLACE);
  assign bus.busy      = (state != IDLE);
  assign bus.game_over = (state == OVER);
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_piece_move_scheduler.sv
// Self-checking bench for piece_move_scheduler: scenario tasks plus a scoreboard of expected bricks.
module tb_piece_move_scheduler;
  localparam int XW = 5;
  localparam int YW = 5;
  localparam int PW = XW + YW;
  localparam int W  = PW + 5;
  localparam int K_LEFT = 0, K_RIGHT = 1, K_DOWN = 2, K_ROT = 3, K_TYPE = 4, K_DROP = 5;

  logic          clk;
  logic          rst_n;
  logic [5:0]    keys;
  logic          grav;
  logic [2:0]    spawn_type;
  logic          coll_all;
  logic          coll_row_en;
  logic [YW-1:0] coll_row;

  int checks = 0;
  int errors = 0;
  int place_cnt = 0;
  logic [PW-1:0] last_place_pos;
  logic [PW-1:0] spawn_pos;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_v;
  logic [W-1:0]  act_v;

  logic [XW-1:0] m_x;
  logic [YW-1:0] m_y;
  logic [1:0]    m_dir;
  logic [2:0]    m_type;

  piece_move_scheduler_if #(.XW(XW), .YW(YW)) bus ();

  piece_move_scheduler #(.XW(XW), .YW(YW), .SPAWN_X(6), .SPAWN_Y(18)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req_left    = keys[K_LEFT];
  assign bus.req_right   = keys[K_RIGHT];
  assign bus.req_down    = keys[K_DOWN];
  assign bus.req_rot     = keys[K_ROT];
  assign bus.req_type    = keys[K_TYPE];
  assign bus.req_drop    = keys[K_DROP];
  assign bus.grav_tick   = grav;
  assign bus.spawn_type  = spawn_type;
  // Board model: everything blocked, or a single blocked row.
  assign bus.is_collided = coll_all | (coll_row_en && (bus.try_pos[YW-1:0] == coll_row));
  assign act_v = {bus.cur_pos, bus.cur_dir, bus.cur_type};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.place === 1'b1) begin
      place_cnt++;
      last_place_pos = bus.cur_pos;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    keys = '0;
    grav = 1'b0;
    coll_all = 1'b0;
    coll_row_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_x = 5'd6; m_y = 5'd18; m_dir = 2'd0; m_type = 3'd1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      n++;
      tick();
    end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout after %0d cycles", n);
    end
  endtask

  task automatic run_key(input int k, output int busy_cycles);
    keys = '0;
    keys[k] = 1'b1;
    tick();
    keys = '0;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 40) begin
      busy_cycles++;
      tick();
    end
    if (busy_cycles >= 40) begin
      checks++; errors++;
      $display("FAIL run_key timeout key %0d", k);
    end
  endtask

  // reference model of one key transaction from IDLE
  task automatic model_key(input int k, input logic coll, output int places);
    places = 0;
    case (k)
      K_LEFT:  if (!coll) m_x = m_x - XW'(1);
      K_RIGHT: if (!coll) m_x = m_x + XW'(1);
      K_ROT:   if (!coll) m_dir = m_dir + 2'd1;
      K_TYPE:  if (!coll) m_type = (m_type == 3'd7) ? 3'd1 : m_type + 3'd1;
      K_DOWN: begin
        if (m_y == '0 || coll) begin
          places = 1;
          m_x = 5'd6; m_y = 5'd18; m_dir = 2'd0; m_type = spawn_type;
        end else begin
          m_y = m_y - YW'(1);
        end
      end
      default: places = 0;
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cur_pos !== spawn_pos) begin errors++; $display("FAIL reset_cur_pos got %h exp %h", bus.cur_pos, spawn_pos); end
    checks++; if (bus.try_pos !== spawn_pos) begin errors++; $display("FAIL reset_try_pos got %h exp %h", bus.try_pos, spawn_pos); end
    checks++; if ({bus.cur_dir, bus.cur_type} !== 5'b00_001) begin errors++; $display("FAIL reset_dir_type got %b exp 00001", {bus.cur_dir, bus.cur_type}); end
    checks++; if ({bus.place, bus.busy, bus.game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus.place, bus.busy, bus.game_over}); end
    checks++; if (bus.state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_dbg); end
  endtask

  task automatic test_single_moves();
    int bc, pl;
    int seq[5] = '{K_RIGHT, K_LEFT, K_DOWN, K_ROT, K_TYPE};
    do_reset();
    foreach (seq[i]) begin
      model_key(seq[i], 1'b0, pl);
      exp_q.push_back({m_x, m_y, m_dir, m_type});
      run_key(seq[i], bc);
      exp_v = exp_q.pop_front();
      checks++; if (act_v !== exp_v) begin errors++; $display("FAIL single_move k%0d got %h exp %h", seq[i], act_v, exp_v); end
      checks++; if (bc != 1) begin errors++; $display("FAIL single_busy k%0d got %0d exp 1", seq[i], bc); end
    end
  endtask

  task automatic test_collide();
    int bc, p0;
    do_reset();
    coll_all = 1'b1;
    p0 = place_cnt;
    run_key(K_LEFT, bc);
    tick();
    checks++; if (bus.cur_pos !== spawn_pos) begin errors++; $display("FAIL collide_pos got %h exp %h", bus.cur_pos, spawn_pos); end
    checks++; if (place_cnt != p0) begin errors++; $display("FAIL collide_place got %0d exp %0d", place_cnt, p0); end
    checks++; if (bc != 1 || bus.state_dbg !== 3'd0) begin errors++; $display("FAIL collide_idle got busy %0d state %0d exp 1 0", bc, bus.state_dbg); end
    checks++; if (bus.try_pos !== bus.cur_pos) begin errors++; $display("FAIL collide_try got %h exp %h", bus.try_pos, bus.cur_pos); end
    coll_all = 1'b0;
  endtask

  task automatic test_random();
    int k, bc, pl, p0;
    logic coll;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      coll = 1'b0;
      if (k != K_DOWN) coll = ($urandom_range(0, 1) == 1);
      spawn_type = 3'($urandom_range(1, 7));
      coll_all = coll;
      model_key(k, coll, pl);
      exp_q.push_back({m_x, m_y, m_dir, m_type});
      p0 = place_cnt;
      run_key(k, bc);
      tick();
      exp_v = exp_q.pop_front();
      checks++; if (act_v !== exp_v) begin errors++; $display("FAIL random_cur i%0d k%0d got %h exp %h", i, k, act_v, exp_v); end
      checks++; if (place_cnt - p0 != pl) begin errors++; $display("FAIL random_place i%0d got %0d exp %0d", i, place_cnt - p0, pl); end
      checks++; if ({bus.try_pos, bus.try_dir, bus.try_type} !== act_v) begin errors++; $display("FAIL random_try i%0d got %h exp %h", i, {bus.try_pos, bus.try_dir, bus.try_type}, act_v); end
    end
    coll_all = 1'b0;
  endtask

  task automatic test_floor_grav();
    int bc, pl, p0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      model_key(K_DOWN, 1'b0, pl);
      run_key(K_DOWN, bc);
    end
    checks++; if (bus.cur_pos !== {5'd6, 5'd0}) begin errors++; $display("FAIL floor_reach got %h exp %h", bus.cur_pos, {5'd6, 5'd0}); end
    spawn_type = 3'd5;
    p0 = place_cnt;
    grav = 1'b1;
    tick();
    grav = 1'b0;
    checks++; if (bus.place !== 1'b1 || bus.cur_pos !== {5'd6, 5'd0}) begin errors++; $display("FAIL floor_place got place %b pos %h exp 1 %h", bus.place, bus.cur_pos, {5'd6, 5'd0}); end
    wait_idle(20);
    tick();
    exp_v = {spawn_pos, 2'd0, 3'd5};
    checks++; if (act_v !== exp_v) begin errors++; $display("FAIL floor_spawn got %h exp %h", act_v, exp_v); end
    checks++; if (place_cnt - p0 != 1) begin errors++; $display("FAIL floor_place_cnt got %0d exp 1", place_cnt - p0); end
  endtask

  task automatic test_pending_grav();
    do_reset();
    keys[K_ROT] = 1'b1;
    tick();
    keys = '0;
    grav = 1'b1;
    tick();
    grav = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.cur_dir !== 2'd1 || bus.cur_pos !== spawn_pos) begin errors++; $display("FAIL pend_rot got busy %b dir %0d pos %h exp 0 1 %h", bus.busy, bus.cur_dir, bus.cur_pos, spawn_pos); end
    tick();
    tick();
    checks++; if (bus.cur_pos !== {5'd6, 5'd17} || bus.cur_dir !== 2'd1) begin errors++; $display("FAIL pend_grav got pos %h dir %0d exp %h 1", bus.cur_pos, bus.cur_dir, {5'd6, 5'd17}); end
    tick(); tick(); tick();
    checks++; if (bus.cur_pos !== {5'd6, 5'd17}) begin errors++; $display("FAIL pend_once got %h exp %h", bus.cur_pos, {5'd6, 5'd17}); end
  endtask

  task automatic test_drop();
    int p0;
    logic [PW-1:0] exp_place;
`ifdef HARD_DROP_EN
    exp_place = {5'd6, 5'd4};
`else
    exp_place = {5'd6, 5'd18};
`endif
    do_reset();
    spawn_type = 3'd3;
    coll_row_en = 1'b1;
    coll_row = 5'd3;
    p0 = place_cnt;
    keys[K_DROP] = 1'b1;
    tick();
    keys = '0;
    wait_idle(100);
    tick();
    coll_row_en = 1'b0;
    checks++; if (place_cnt - p0 != 1) begin errors++; $display("FAIL drop_place_cnt got %0d exp 1", place_cnt - p0); end
    checks++; if (last_place_pos !== exp_place) begin errors++; $display("FAIL drop_place_pos got %h exp %h", last_place_pos, exp_place); end
    exp_v = {spawn_pos, 2'd0, 3'd3};
    checks++; if (act_v !== exp_v) begin errors++; $display("FAIL drop_spawn got %h exp %h", act_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    keys[K_RIGHT] = 1'b1;
    tick();
    keys = '0;
    keys[K_LEFT] = 1'b1;
    tick();
    keys = '0;
    wait_idle(10);
    tick();
    checks++; if (bus.cur_pos !== {5'd7, 5'd18}) begin errors++; $display("FAIL b2b_drop_busy got %h exp %h", bus.cur_pos, {5'd7, 5'd18}); end
    keys = 6'b001011;
    tick();
    keys = '0;
    wait_idle(10);
    checks++; if (bus.cur_pos !== {5'd6, 5'd18} || bus.cur_dir !== 2'd0) begin errors++; $display("FAIL prio_left got %h dir %0d exp %h 0", bus.cur_pos, bus.cur_dir, {5'd6, 5'd18}); end
    keys = 6'b000101;
    grav = 1'b1;
    tick();
    keys = '0;
    grav = 1'b0;
    wait_idle(10);
    tick();
    checks++; if (bus.cur_pos !== {5'd6, 5'd17}) begin errors++; $display("FAIL prio_grav got %h exp %h", bus.cur_pos, {5'd6, 5'd17}); end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    coll_all = 1'b1;
    p0 = place_cnt;
    keys[K_DOWN] = 1'b1;
    tick();
    keys = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    coll_all = 1'b0;
    tick(); tick();
    checks++; if (place_cnt != p0) begin errors++; $display("FAIL rstmid_place got %0d exp %0d", place_cnt, p0); end
    checks++; if (bus.cur_pos !== spawn_pos || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got %h busy %b exp %h 0", bus.cur_pos, bus.busy, spawn_pos); end
  endtask

  task automatic test_game_over();
    int p0, n;
    logic [W-1:0] frozen;
    do_reset();
    spawn_type = 3'd6;
    coll_all = 1'b1;
    p0 = place_cnt;
    keys[K_DROP] = 1'b1;
    tick();
    keys = '0;
    n = 0;
    while (bus.game_over !== 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (bus.game_over !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL over_flag got %b busy %b exp 1 1", bus.game_over, bus.busy); end
    checks++; if (place_cnt - p0 != 1) begin errors++; $display("FAIL over_place got %0d exp 1", place_cnt - p0); end
    frozen = {spawn_pos, 2'd0, 3'd6};
    coll_all = 1'b0;
    keys = 6'b111111;
    grav = 1'b1;
    tick();
    keys = '0;
    grav = 1'b0;
    tick(); tick(); tick();
    checks++; if (act_v !== frozen || bus.game_over !== 1'b1) begin errors++; $display("FAIL over_frozen got %h over %b exp %h 1", act_v, bus.game_over, frozen); end
    checks++; if (place_cnt - p0 != 1) begin errors++; $display("FAIL over_noplace got %0d exp 1", place_cnt - p0); end
    do_reset();
    checks++; if (bus.game_over !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL over_clear got %b busy %b exp 0 0", bus.game_over, bus.busy); end
  endtask

  initial begin
    spawn_pos = {5'd6, 5'd18};
    spawn_type = 3'd2;
    rst_n = 1'b0;
    keys = '0;
    grav = 1'b0;
    coll_all = 1'b0;
    coll_row_en = 1'b0;
    coll_row = '0;
    test_reset();
    test_single_moves();
    test_collide();
    test_random();
    test_floor_grav();
    test_pending_grav();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_game_over();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piece_move_scheduler.md
PIECE_MOVE_SCHEDULER -- requirements
Module: piece_move_scheduler

Interface
REQ-001 Parameter XW, default 5, x-coordinate width; pos = {x, y}.
REQ-002 Parameter YW, default 5, y-coordinate width; y decreases toward the board floor.
REQ-003 Parameter SPAWN_X, default 6, spawn column.
REQ-004 Parameter SPAWN_Y, default 18, spawn row.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_left, req_right, req_down, req_rot, req_type, req_drop  input  1 each  one-cycle key pulses.
REQ-008 grav_tick  input  1  one-cycle gravity pulse.
REQ-009 spawn_type  input  3  brick type (1..7) for the next spawn.
REQ-010 is_collided  input  1  external collision-checker result for try_* against the placed board.
REQ-011 try_pos  output  XW+YW  candidate position; try_dir  output  2; try_type  output  3.
REQ-012 cur_pos  output  XW+YW; cur_dir  output  2; cur_type  output  3; committed brick.
REQ-013 place  output  1  one-cycle pulse: write cur_* brick into the board.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 game_over  output  1  sticky end-of-game flag.

Function
REQ-016 States: IDLE, CHECK, PLACE, SPAWN, SPAWN_CHK, OVER.
REQ-017 IDLE: with no request pending, try_* SHALL equal cur_*.
REQ-018 IDLE arbitration, one winner per cycle, fixed priority: drop > grav (incl. pending) > down > left > right > rot > type.
REQ-019 Candidates: down/grav y-1; left x-1; right x+1; rot dir+1 mod 4; type = 7 ? 1 : type+1; all others copied from cur_*.
REQ-020 Winner: register candidate into try_*, go CHECK; losing and busy-state key pulses SHALL be dropped.
REQ-021 A grav_tick arriving while busy SHALL set a one-deep pending flag, served on the next IDLE cycle; extra ticks are merged.
REQ-022 CHECK (one cycle, is_collided sampled): clear -> cur_* <= try_*, IDLE; collided on grav/down -> PLACE; collided on any other move -> IDLE, cur_* unchanged.
REQ-023 Down or grav with cur y == 0 SHALL skip CHECK and go straight to PLACE (no y wrap).
REQ-024 PLACE: place = 1 for exactly one cycle with cur_* stable, then SPAWN.
REQ-025 SPAWN: cur_pos <= {SPAWN_X, SPAWN_Y}, cur_dir <= 0, cur_type <= spawn_type; try_* loaded identically; go SPAWN_CHK.
REQ-026 SPAWN_CHK: collided -> OVER, else IDLE.
REQ-027 OVER: game_over = 1, all requests ignored, outputs frozen until reset.
REQ-028 Latency: move request to updated cur_* = 2 clocks (IDLE, CHECK).

Reset
REQ-029 While rst_n == 0 at clk edge: state IDLE, cur_pos = try_pos = {SPAWN_X, SPAWN_Y}, dir 0, type 1, place 0, busy 0, game_over 0, pending 0.
REQ-030 Reset mid-operation SHALL abort any move or drop without a place pulse.

Configuration
REQ-031 Macro HARD_DROP_EN defined: req_drop loops CHECK with y-1 until collision or y == 0, then PLACE; cur_* tracks each successful step.
REQ-032 HARD_DROP_EN undefined: req_drop goes directly to PLACE at current cur_*, no collision check.

Verification
REQ-033 Reset, no collisions, req_right -> cur_pos x 6->7 two clocks later, busy high for 1 cycle.
REQ-034 is_collided forced 1, req_left -> cur_pos unchanged, no place pulse, IDLE after CHECK.
REQ-035 cur y = 0, grav_tick -> place pulse next cycle, then spawn at (6,18), dir 0, type = spawn_type.
REQ-036 grav_tick during CHECK of req_rot -> rotation resolves, then gravity step y-1 served without a new tick.
REQ-037 HARD_DROP_EN, from y = 18, collision when y = 3 -> cur y ends at 4, one place pulse; without macro -> place at y = 18.
REQ-038 is_collided = 1 in SPAWN_CHK -> game_over = 1, subsequent requests ignored, cleared only by rst_n = 0.
